uart_rx_ctrl: RTL

//  Controller for the UART receive datapath: owns the receiver's enable and baud compare value,

---
 rtl/uart_rx_ctrl_if.sv | 11 +
 rtl/uart_rx_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Byte stream from the UART receive controller towards the bus/register slave.
// Latency: none (wires only).
// Backpressure: consumer deasserts m_ready; producer holds m_data/m_valid stable.
interface uart_rx_ctrl_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_valid, input  m_ready);
    modport slave  (input  m_data, input  m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: receiver enable/baud sequencing plus a FWFT byte FIFO.
// Latency: a byte edge at cycle N is on m_data at N+1; rx_val_set pulses at N+1.
// Backpressure: m_ready low holds bytes in the FIFO; a byte arriving when full is dropped and flags ovr.

// Generic first-word fall-through FIFO with flush and drop-on-full.
// Latency: a push at edge N is visible on pop_dat/pop_vld after that edge.
// Backpressure: full FIFO refuses a push unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_rdy,
    output logic                     pop_vld,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          push_fire;
    logic          pop_fire;

    assign full      = (cnt == LW'(DEPTH));
    assign empty     = (cnt == '0);
    // Pop only when something is held, so push+pop on empty degenerates to a push.
    assign pop_fire  = pop_rdy && !empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push_fire = push_vld && (!full || pop_fire);
    // Flush discards everything anyway, so a push racing it is not an overrun.
    assign drop      = push_vld && full && !pop_fire && !flush;

    assign pop_vld = !empty;
    // Empty FIFO presents zero rather than stale storage.
    assign pop_dat = empty ? '0 : mem[rd_ptr];
    assign level   = cnt;

    // Pointer and occupancy tracking; flush overrides any push or pop.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage write; contents need no reset because the output is masked when empty.
    always_ff @(posedge clk) begin
        if (rstn && !flush && push_fire) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

// Receive controller top: owns rec_en/comp, acknowledges captured bytes, buffers them.
// Latency: byte on m_data one cycle after the rx_valid rising edge; rec_en follows state with one register.
// Backpressure: m_ready low stalls the FIFO; overflow drops the new byte and sets sticky ovr.
module uart_rx_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] COMP_RST = 16'd434,
    parameter int          RECONF_C = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cfg_en,
    input  logic                   cfg_wr,
    input  logic [15:0]            cfg_comp,
    input  logic                   flush,
    input  logic                   ovr_clr,
    uart_rx_ctrl_if.master         m_if,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovr,
    output logic                   cfg_busy,
    output logic                   rec_en,
    output logic [15:0]            comp,
    output logic                   rx_val_set,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid
);
    localparam int CW = (RECONF_C > 1) ? $clog2(RECONF_C) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RECONF_C - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_RUN    = 2'd1,
        ST_RECONF = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          rx_valid_q;
    logic          byte_evt;
    logic          fifo_drop;

    // State and reconfiguration counter registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a baud write beats the enable level in every state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                if (cfg_wr) begin
                    state_d = ST_RECONF;
                    cnt_d   = '0;
                end else if (cfg_en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cfg_wr) begin
                    state_d = ST_RECONF;
                    cnt_d   = '0;
                end else if (!cfg_en) begin
                    state_d = ST_OFF;
                end
            end
            ST_RECONF: begin
                if (cfg_wr) begin
                    // A fresh value restarts the quiet window in full.
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = cfg_en ? ST_RUN : ST_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered decode of the state so rec_en/cfg_busy are glitch-free to the receiver.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rec_en   <= 1'b0;
            cfg_busy <= 1'b0;
        end else begin
            rec_en   <= (state_d == ST_RUN);
            cfg_busy <= (state_d == ST_RECONF);
        end
    end

    // Baud compare value; loads on the same edge that drops rec_en, so the receiver never runs on a half-applied value.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            comp <= COMP_RST;
        end else if (cfg_wr) begin
            comp <= (cfg_comp == 16'd0) ? 16'd1 : cfg_comp;
        end
    end

    // Only a rising edge of rx_valid counts, so a long valid pulse yields one byte.
    assign byte_evt = rx_valid && !rx_valid_q && (state_q == ST_RUN);

    // Edge detector history and one-cycle acknowledge back to the receiver.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_valid_q <= 1'b0;
            rx_val_set <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            rx_val_set <= byte_evt;
        end
    end

    uart_rx_fifo #(
        .W     (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .push_vld (byte_evt),
        .push_dat (rx_data),
        .pop_rdy  (m_if.m_ready),
        .pop_vld  (m_if.m_valid),
        .pop_dat  (m_if.m_data),
        .level    (level),
        .drop     (fifo_drop)
    );

    // Sticky overrun; a new drop beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovr <= 1'b0;
        end else if (fifo_drop) begin
            ovr <= 1'b1;
        end else if (ovr_clr) begin
            ovr <= 1'b0;
        end
    end
endmodule
